// File: rtl/riscv_m_ext_unit.sv
// RV32M execution unit: single-cycle multiplier plus a 32-step restoring divider.
// Results appear on rd with a one-cycle ready/wr pulse.
module riscv_m_ext_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic [31:0] instruction,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        wr,
   output logic [31:0] rd,
   output logic        busy,
   output logic        ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV_SETUP,
      S_DIV_RUN,
      S_DONE
   } state_t;

   state_t      state_reg;
   logic [2:0]  funct3_reg;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [31:0] result_reg;
   logic [31:0] rem_reg;
   logic [31:0] quo_reg;
   logic [31:0] divisor_reg;
   logic [4:0]  count_reg;
   logic        neg_q_reg;
   logic        neg_r_reg;
   logic        ready_reg;
   logic        busy_reg;
   logic [31:0] rd_reg;

   logic decode_ok;
   logic accept;

   assign decode_ok = (instruction[6:0] == 7'b0110011) && (instruction[31:25] == 7'b0000001);
   // The ready cycle is spent in IDLE, so it must also block a new accept.
   assign accept    = valid && decode_ok && (state_reg == S_IDLE) && !ready_reg;

   logic               a_sext;
   logic               b_sext;
   logic signed [65:0] prod;
   logic [31:0]        mul_result;

   assign a_sext     = (funct3_reg != 3'b011) & a_reg[31];
   assign b_sext     = ~funct3_reg[1] & b_reg[31];
   assign prod       = $signed({a_sext, a_reg}) * $signed({b_sext, b_reg});
   assign mul_result = (funct3_reg[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

   logic        is_signed;
   logic        is_rem;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic        div_overflow;
   logic [32:0] shifted;
   logic [32:0] diff;
   logic [31:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] q_final;
   logic [31:0] r_final;

   assign is_signed    = ~funct3_reg[0];
   assign is_rem       = funct3_reg[1];
   assign a_neg        = is_signed & a_reg[31];
   assign b_neg        = is_signed & b_reg[31];
   assign a_abs        = a_neg ? (32'd0 - a_reg) : a_reg;
   assign b_abs        = b_neg ? (32'd0 - b_reg) : b_reg;
   assign div_overflow = is_signed && (a_reg == 32'h80000000) && (b_reg == 32'hFFFFFFFF);

   // One restoring step: shift the next dividend bit in, keep the difference if non-negative.
   assign shifted  = {rem_reg, quo_reg[31]};
   assign diff     = shifted - {1'b0, divisor_reg};
   assign rem_next = diff[32] ? shifted[31:0] : diff[31:0];
   assign quo_next = {quo_reg[30:0], ~diff[32]};
   assign q_final  = neg_q_reg ? (32'd0 - quo_next) : quo_next;
   assign r_final  = neg_r_reg ? (32'd0 - rem_next) : rem_next;

   logic unused_bits;
   assign unused_bits = ^{instruction[24:15], instruction[11:7], prod[65:64]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         funct3_reg  <= 3'd0;
         a_reg       <= 32'd0;
         b_reg       <= 32'd0;
         result_reg  <= 32'd0;
         rem_reg     <= 32'd0;
         quo_reg     <= 32'd0;
         divisor_reg <= 32'd0;
         count_reg   <= 5'd0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         ready_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         rd_reg      <= 32'd0;
      end else begin
         ready_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (ready_reg) begin
                  busy_reg <= 1'b0;
               end
               if (accept) begin
                  funct3_reg <= instruction[14:12];
                  a_reg      <= rs1;
                  b_reg      <= rs2;
                  busy_reg   <= 1'b1;
                  state_reg  <= instruction[14] ? S_DIV_SETUP : S_MUL;
               end
            end
            S_MUL: begin
               result_reg <= mul_result;
               state_reg  <= S_DONE;
            end
            S_DIV_SETUP: begin
               if (b_reg == 32'd0) begin
                  result_reg <= is_rem ? a_reg : 32'hFFFFFFFF;
                  state_reg  <= S_DONE;
               end else if (div_overflow) begin
                  result_reg <= is_rem ? 32'd0 : 32'h80000000;
                  state_reg  <= S_DONE;
               end else begin
                  rem_reg     <= 32'd0;
                  quo_reg     <= a_abs;
                  divisor_reg <= b_abs;
                  count_reg   <= 5'd0;
                  neg_q_reg   <= a_neg ^ b_neg;
                  neg_r_reg   <= a_neg;
                  state_reg   <= S_DIV_RUN;
               end
            end
            S_DIV_RUN: begin
               rem_reg   <= rem_next;
               quo_reg   <= quo_next;
               count_reg <= count_reg + 5'd1;
               if (count_reg == 5'd31) begin
                  result_reg <= is_rem ? r_final : q_final;
                  state_reg  <= S_DONE;
               end
            end
            S_DONE: begin
               rd_reg    <= result_reg;
               ready_reg <= 1'b1;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign ready = ready_reg;
   assign wr    = ready_reg;
   assign busy  = busy_reg;
   assign rd    = rd_reg;

endmodule

// File: tb/tb_riscv_m_ext_unit.sv
// Directed bench for riscv_m_ext_unit: arithmetic vectors, special cases and control behaviour.
module tb_riscv_m_ext_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [31:0] instruction;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        wr;
   logic [31:0] rd;
   logic        busy;
   logic        ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_m_ext_unit dut (
      .clk         (clk),
      .reset       (reset),
      .valid       (valid),
      .instruction (instruction),
      .rs1         (rs1),
      .rs2         (rs2),
      .wr          (wr),
      .rd          (rd),
      .busy        (busy),
      .ready       (ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end else begin
         $display("ok   %s: %08h", tag, obs);
      end
   endtask

   function automatic logic [31:0] enc(input logic [2:0] f3);
      return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction

   // exp_lat > 0 demands that exact latency; 0 means "at most 34 cycles".
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      bit seen;
      @(negedge clk);
      valid = 1'b1; instruction = enc(f3); rs1 = a; rs2 = b;
      @(posedge clk); #1;
      valid = 1'b0; rs1 = $urandom; rs2 = $urandom;
      check({tag, " accept-ready"}, {31'd0, ready}, 32'd0);
      check({tag, " accept-busy"}, {31'd0, busy}, 32'd1);
      lat = 0; seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (ready) seen = 1'b1;
      end
      check({tag, " ready-seen"}, {31'd0, seen}, 32'd1);
      if (seen) begin
         check(tag, rd, exp);
         check({tag, " wr"}, {31'd0, wr}, 32'd1);
         if (exp_lat > 0) check({tag, " latency"}, lat, exp_lat);
         else             check({tag, " latency<=34"}, {31'd0, lat <= 34}, 32'd1);
      end
      @(posedge clk); #1;
      check({tag, " ready-pulse"}, {31'd0, ready}, 32'd0);
      check({tag, " busy-clear"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic expect_quiet(input string tag, input int n);
      int cnt = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (ready || wr) cnt++;
      end
      check(tag, cnt, 32'd0);
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; instruction = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset rd", rd, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset ready", {31'd0, ready}, 32'd0);
      check("reset wr", {31'd0, wr}, 32'd0);
      @(negedge clk); reset = 1'b0;

      run_op("MUL 1111FFFF^2",       3'b000, 32'h1111FFFF, 32'h1111FFFF, 32'hDDDC0001, 2);
      run_op("MULHU 1111FFFF^2",     3'b011, 32'h1111FFFF, 32'h1111FFFF, 32'h01236543, 2);
      run_op("MULHU FFFFFFFF^2",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
      run_op("MULH -5*-4",           3'b001, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h00000000, 2);
      run_op("MULH 2*-1",            3'b001, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
      run_op("MULHSU -1*FFFFFFFF",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
      run_op("DIV -13/5",            3'b100, 32'hFFFFFFF3, 32'h00000005, 32'hFFFFFFFE, 0);
      run_op("REM -13%5",            3'b110, 32'hFFFFFFF3, 32'h00000005, 32'hFFFFFFFD, 0);
      run_op("REM 5%-13",            3'b110, 32'h00000005, 32'hFFFFFFF3, 32'h00000005, 0);
      run_op("DIVU D/5",             3'b101, 32'h0000000D, 32'h00000005, 32'h00000002, 0);
      run_op("REMU D%5",             3'b111, 32'h0000000D, 32'h00000005, 32'h00000003, 0);
      run_op("DIVU FFFFFFFF/1",      3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 0);
      run_op("DIV 5/0",              3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 0);
      run_op("DIVU D/0",             3'b101, 32'h0000000D, 32'h00000000, 32'hFFFFFFFF, 0);
      run_op("REM -13%0",            3'b110, 32'hFFFFFFF3, 32'h00000000, 32'hFFFFFFF3, 0);
      run_op("REMU D%0",             3'b111, 32'h0000000D, 32'h00000000, 32'h0000000D, 0);
      run_op("DIV ovf",              3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
      run_op("REM ovf",              3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);

      // valid held high with a different op and operands while a divide is in flight
      begin
         int lat;
         bit seen;
         @(negedge clk);
         valid = 1'b1; instruction = enc(3'b101); rs1 = 32'h0000000D; rs2 = 32'h00000005;
         @(posedge clk); #1;
         instruction = enc(3'b000); rs1 = 32'h00001234; rs2 = 32'h00000010;
         repeat (10) @(posedge clk);
         #1; valid = 1'b0;
         lat = 0; seen = 1'b0;
         while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ready) seen = 1'b1;
         end
         check("busy-ignore ready-seen", {31'd0, seen}, 32'd1);
         check("busy-ignore rd", rd, 32'h00000002);
         expect_quiet("busy-ignore no-extra-ready", 40);
      end

      // non-M words: ADD (funct7=0) and an OP-32 opcode with funct7=1
      @(negedge clk);
      valid = 1'b1; instruction = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
      rs1 = 32'd7; rs2 = 32'd9;
      @(posedge clk); #1;
      valid = 1'b0;
      check("non-M add busy", {31'd0, busy}, 32'd0);
      expect_quiet("non-M add no-ready", 10);
      @(negedge clk);
      valid = 1'b1; instruction = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0111011};
      @(posedge clk); #1;
      valid = 1'b0;
      check("non-M opcode busy", {31'd0, busy}, 32'd0);
      expect_quiet("non-M opcode no-ready", 10);
      check("non-M rd held", rd, 32'h00000002);

      // reset in the middle of a divide
      @(negedge clk);
      valid = 1'b1; instruction = enc(3'b100); rs1 = 32'hFFFFFFF3; rs2 = 32'h00000005;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid-divide busy", {31'd0, busy}, 32'd1);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("reset-mid busy", {31'd0, busy}, 32'd0);
      check("reset-mid ready", {31'd0, ready}, 32'd0);
      check("reset-mid rd", rd, 32'd0);
      @(negedge clk); reset = 1'b0;
      expect_quiet("reset-mid no-ready", 40);

      run_op("MUL after reset",      3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
